// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {PARITY_NONE, PARITY_ODD, PARITY_EVEN} parity_e;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

   function automatic int clk_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with head-of-queue read data and single-cycle flush.
// Zero-latency read of the head; the caller guards push against full and pop against empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         // Flush drops everything queued but keeps a word pushed in the same cycle.
         if (flush)
            rd_ptr <= wr_ptr;
         else if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (flush)
            count <= {{AW{1'b0}}, push};
         else if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a synchronous FIFO; frames go out back-to-back.
// tx is registered and trails the FSM state by one cycle; in_ready drops only when the FIFO is full.
module uart_tx_fifo #(
   parameter int                CLK_HZ     = 100_000_000,
   parameter int                BAUD       = 115200,
   parameter int                DATA_BITS  = 8,
   parameter uart_pkg::parity_e PARITY     = uart_pkg::PARITY_NONE,
   parameter int                STOP_BITS  = 1,
   parameter int                FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [DATA_BITS-1:0]        in_data,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int CPB = uart_pkg::clk_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB);
   localparam int FW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(CPB - 1);

   uart_pkg::tx_state_e  state;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] head;
   logic                 par_bit;
   logic                 push;
   logic                 pop;
   logic                 fifo_empty;
   logic                 bit_done;
   logic                 stop_done;

   assign in_ready   = fifo_count != FW'(FIFO_DEPTH);
   assign fifo_empty = fifo_count == '0;
   assign push       = in_valid && in_ready;
   assign bit_done   = cnt == '0;
   assign stop_done  = (state == uart_pkg::STOP) && bit_done && (bit_idx == 4'(STOP_BITS - 1));
   // Popping straight out of the last stop cycle keeps consecutive frames contiguous.
   assign pop        = !fifo_empty && ((state == uart_pkg::IDLE) || stop_done);
   assign busy       = (state != uart_pkg::IDLE) || !fifo_empty;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (in_data),
      .rdata (head),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= uart_pkg::IDLE;
         cnt     <= CNT_TOP;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         tx      <= 1'b1;
      end else begin
         case (state)
            uart_pkg::START:  tx <= 1'b0;
            uart_pkg::DATA:   tx <= shreg[0];
            uart_pkg::PARITY: tx <= par_bit;
            default:          tx <= 1'b1;
         endcase

         if (pop) begin
            shreg   <= head;
            state   <= uart_pkg::START;
            cnt     <= CNT_TOP;
            bit_idx <= '0;
            if (PARITY == uart_pkg::PARITY_ODD)
               par_bit <= ~^head;
            else
               par_bit <= ^head;
         end else if (state != uart_pkg::IDLE) begin
            if (!bit_done) begin
               cnt <= cnt - CW'(1);
            end else begin
               cnt <= CNT_TOP;
               case (state)
                  uart_pkg::START: begin
                     state   <= uart_pkg::DATA;
                     bit_idx <= '0;
                  end
                  uart_pkg::DATA: begin
                     shreg <= shreg >> 1;
                     if (bit_idx == 4'(DATA_BITS - 1)) begin
                        bit_idx <= '0;
                        if (PARITY == uart_pkg::PARITY_NONE)
                           state <= uart_pkg::STOP;
                        else
                           state <= uart_pkg::PARITY;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
                  uart_pkg::PARITY: begin
                     state   <= uart_pkg::STOP;
                     bit_idx <= '0;
                  end
                  uart_pkg::STOP: begin
                     if (bit_idx == 4'(STOP_BITS - 1))
                        state <= uart_pkg::IDLE;
                     else
                        bit_idx <= bit_idx + 4'd1;
                  end
                  default: state <= uart_pkg::IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomised checks of uart_tx_fifo: the recorded tx line is compared
// cycle by cycle against frames built from the line format rules and the pushed words.
module tb_uart_tx_fifo;

   localparam int CPB = 10;
   localparam int N   = 8192;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] valid = '0;
   logic [7:0] d_a = '0;
   logic [6:0] d_b = '0;
   logic [7:0] d_c = '0;
   logic       flush_a = 1'b0;

   wire        rdy_a, rdy_b, rdy_c, tx_a, tx_b, tx_c, bsy_a, bsy_b, bsy_c;
   wire [2:0]  cnt_a;
   wire [4:0]  cnt_b, cnt_c;
   wire [2:0]  rdy = {rdy_c, rdy_b, rdy_a};
   wire [2:0]  txl = {tx_c, tx_b, tx_a};
   wire [2:0]  bsy = {bsy_c, bsy_b, bsy_a};

   int   cyc = 0;
   logic wav [3][N];
   logic bw  [3][N];
   int   maxcnt = 0;
   logic mc_clr = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   q[$];

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(uart_pkg::PARITY_NONE),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset(reset), .in_valid(valid[0]), .in_data(d_a), .in_ready(rdy_a),
      .flush(flush_a), .tx(tx_a), .busy(bsy_a), .fifo_count(cnt_a));

   uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(uart_pkg::PARITY_EVEN),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
      .clk(clk), .reset(reset), .in_valid(valid[1]), .in_data(d_b), .in_ready(rdy_b),
      .flush(1'b0), .tx(tx_b), .busy(bsy_b), .fifo_count(cnt_b));

   uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(uart_pkg::PARITY_ODD),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dut_c (
      .clk(clk), .reset(reset), .in_valid(valid[2]), .in_data(d_c), .in_ready(rdy_c),
      .flush(1'b0), .tx(tx_c), .busy(bsy_c), .fifo_count(cnt_c));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < N) begin
         for (int k = 0; k < 3; k++) begin
            wav[k][cyc] = txl[k];
            bw[k][cyc]  = bsy[k];
         end
      end
      if (mc_clr) maxcnt = 0;
      else if (int'(cnt_a) > maxcnt) maxcnt = int'(cnt_a);
   end

   initial begin
      #(N * 10);
      $display("FAIL watchdog: observed %0d cycles, expected completion earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
   task automatic push(input int k, input int val, output int acc);
      acc = -1;
      valid[k] = 1'b1;
      case (k)
         0:       d_a = 8'(val);
         1:       d_b = 7'(val);
         default: d_c = 8'(val);
      endcase
      for (int t = 0; t < 400; t++) begin
         if (rdy[k]) begin
            acc = cyc + 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      check("push accepted", acc >= 0, 1);
   endtask

   task automatic wait_idle(input int k);
      int t;
      t = 0;
      while (bsy[k] && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("idle in time", t < 3000, 1);
      repeat (15) @(negedge clk);
   endtask

   task automatic check_stream(input int k, input int from, input int to, input int db,
                               input int par, input int sb, input int words[$],
                               input bit contig, output int first_st);
      int nbits, flen, pos, prev, st, bad, word, eb, ones;
      nbits = 1 + db + ((par != 0) ? 1 : 0) + sb;
      flen = nbits * CPB;
      pos = from;
      prev = -1;
      first_st = -1;
      foreach (words[f]) begin
         st = -1;
         for (int i = pos; i < to; i++) begin
            if (wav[k][i] === 1'b0 && wav[k][i-1] === 1'b1) begin
               st = i;
               break;
            end
         end
         check("frame found", (st >= 0) && (st + flen <= to), 1);
         if (!((st >= 0) && (st + flen <= to))) return;
         if (first_st < 0) first_st = st;
         if (contig && prev >= 0) check("contiguous start", st, prev + flen);
         ones = $countones(words[f]);
         bad = 0;
         word = 0;
         for (int b = 0; b < nbits; b++) begin
            if (b == 0) eb = 0;
            else if (b <= db) eb = (words[f] >> (b - 1)) & 1;
            else if (par != 0 && b == db + 1) eb = (par == 1) ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
            else eb = 1;
            if (b >= 1 && b <= db && wav[k][st + b*CPB + CPB/2] === 1'b1) word |= 1 << (b - 1);
            for (int c = 0; c < CPB; c++)
               if (wav[k][st + b*CPB + c] !== 1'(eb)) bad++;
         end
         check("frame data", word, words[f]);
         check("frame waveform bad cycles", bad, 0);
         prev = st;
         pos = st + flen;
      end
      st = 0;
      for (int i = pos; i < to; i++)
         if (wav[k][i] !== 1'b1) st++;
      check("line idle after frames", st, 0);
   endtask

   initial begin
      int acc, acc0, st, from, w, n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("reset tx", txl[k], 1);
         check("reset in_ready", rdy[k], 1);
         check("reset busy", bsy[k], 0);
      end
      check("reset count a", cnt_a, 0);
      check("reset count b", cnt_b, 0);

      // 8N1 single character
      from = cyc;
      q = {};
      q.push_back(8'h4D);
      push(0, 8'h4D, acc);
      valid[0] = 1'b0;
      check("count after accept", cnt_a, 1);
      wait_idle(0);
      check_stream(0, from, cyc, 8, 0, 1, q, 1'b1, st);
      check("tx fall after accept", st - acc, 2);
      check("busy in last stop cycle", bw[0][st + 98], 1);
      check("busy low after frame", bw[0][st + 99], 0);

      // 7E2
      from = cyc;
      q = {};
      q.push_back(7'h41);
      push(1, 7'h41, acc);
      valid[1] = 1'b0;
      wait_idle(1);
      check_stream(1, from, cyc, 7, 2, 2, q, 1'b1, st);
      check("7E2 busy in last stop cycle", bw[1][st + 108], 1);
      check("7E2 busy low after frame", bw[1][st + 109], 0);

      // 8O1 parity of 0x00 and 0x01, back to back
      from = cyc;
      q = {};
      q.push_back(8'h00);
      q.push_back(8'h01);
      push(2, 8'h00, acc);
      push(2, 8'h01, acc);
      valid[2] = 1'b0;
      wait_idle(2);
      check_stream(2, from, cyc, 8, 1, 1, q, 1'b1, st);

      // Depth-4 FIFO with in_valid held over 0x30..0x37
      mc_clr = 1'b0;
      from = cyc;
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(8'h30 + i);
      for (int i = 0; i < 5; i++) push(0, 8'h30 + i, acc);
      check("full count", cnt_a, 4);
      check("full in_ready", rdy[0], 0);
      for (int i = 5; i < 8; i++) push(0, 8'h30 + i, acc);
      valid[0] = 1'b0;
      wait_idle(0);
      check_stream(0, from, cyc, 8, 0, 1, q, 1'b1, st);
      check("max fifo_count", maxcnt, 4);
      mc_clr = 1'b1;

      // Flush mid-frame with a coincident push
      from = cyc;
      q = {};
      w = $urandom_range(0, 255);
      q.push_back(w);
      q.push_back(8'h55);
      push(0, w, acc);
      push(0, $urandom_range(0, 255), acc);
      push(0, $urandom_range(0, 255), acc);
      valid[0] = 1'b0;
      repeat (30) @(negedge clk);
      check("ready before flush", rdy[0], 1);
      valid[0] = 1'b1;
      d_a = 8'h55;
      flush_a = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      flush_a = 1'b0;
      check("count after flush+push", cnt_a, 1);
      wait_idle(0);
      check_stream(0, from, cyc, 8, 0, 1, q, 1'b1, st);

      // Reset during DATA of a frame with another word queued
      push(0, 8'h4D, acc0);
      push(0, $urandom_range(0, 255), acc);
      valid[0] = 1'b0;
      repeat (25) @(negedge clk);
      check("tx low in data bit 1", txl[0], 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("tx high after reset", txl[0], 1);
      check("count zero after reset", cnt_a, 0);
      check("busy low after reset", bsy[0], 0);
      @(negedge clk);
      from = cyc;
      q = {};
      q.push_back(8'h4D);
      push(0, 8'h4D, acc);
      valid[0] = 1'b0;
      wait_idle(0);
      check_stream(0, from, cyc, 8, 0, 1, q, 1'b1, st);
      check("tx fall after reset push", st - acc, 2);

      // Random words with random gaps on each configuration
      for (int k = 0; k < 3; k++) begin
         from = cyc;
         q = {};
         n = 4;
         for (int i = 0; i < n; i++) begin
            w = (k == 1) ? $urandom_range(0, 127) : $urandom_range(0, 255);
            q.push_back(w);
            push(k, w, acc);
            valid[k] = 1'b0;
            repeat ($urandom_range(0, 120)) @(negedge clk);
         end
         wait_idle(k);
         if (k == 0) check_stream(0, from, cyc, 8, 0, 1, q, 1'b0, st);
         else if (k == 1) check_stream(1, from, cyc, 7, 2, 2, q, 1'b0, st);
         else check_stream(2, from, cyc, 8, 1, 1, q, 1'b0, st);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated synchronous FIFO, replacing the fixed 8N1/115200 transmit path and its array-polling buffer. Producers (CPU core, debug tracer) push characters through a valid/ready handshake. The block serialises them back-to-back with configurable data width, parity and stop bits, and drives the board's UART TX pin.

## Interface
- CLK_HZ, 100_000_000: clock frequency in Hz.
- BAUD, 115200: line rate. CLK_PER_BIT = CLK_HZ/BAUD, integer division, must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, PARITY_NONE: PARITY_NONE, PARITY_ODD or PARITY_EVEN.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 16: entries; must be a power of two, ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a character.
- in_data  in  DATA_BITS  character; sampled when in_valid && in_ready.
- in_ready  out  1  FIFO not full.
- flush  in  1  discard all queued (not yet started) characters.
- tx  out  1  serial line, idle high; registered.
- busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries, excluding the frame on the wire.

## Operation
- Handshake: a push occurs on a rising edge where in_valid && in_ready. in_valid may drop at any time without penalty.
- in_ready = (fifo_count != FIFO_DEPTH). There is no bypass: when full, in_ready stays low even if a pop occurs in the same cycle.
- Serializer FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLK_PER_BIT cycles, then DATA.
  - DATA: LSB first. DATA_BITS bits, each held CLK_PER_BIT cycles. Then PARITY if PARITY != NONE, else STOP.
  - PARITY: tx = ^data for EVEN, ~^data for ODD. ODD means the total count of ones (data + parity) is odd.
  - STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Bit counter counts CLK_PER_BIT-1 down to 0. The state or bit advances on the cycle the counter reaches 0.
- flush: sets the FIFO read pointer to the write pointer in one cycle. The frame on the wire completes normally.
  - If a push coincides with flush, the pushed word is kept, and fifo_count=1 afterwards.
  - If a pop coincides with flush, the popped word is transmitted.
- Simultaneous push and pop when not full: fifo_count is unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count.

## Timing
- Reset values: tx=1, in_ready=1, busy=0, fifo_count=0, FSM=IDLE, pointers=0, counter=CLK_PER_BIT-1.
- Reset mid-frame: tx returns to 1 on the next edge and the queued data is lost.
- Latency: a push accepted at edge E into an empty, idle block updates fifo_count to 1 at E; the pop happens at E+1 and tx=0 from E+2.
- Frame length: (1 + DATA_BITS + (PARITY!=NONE) + STOP_BITS) * CLK_PER_BIT cycles, exactly.
- Back-to-back frames are contiguous.
- fifo_count decrements on the edge that enters START.
- busy falls on the edge that enters IDLE with an empty FIFO.

## Structure
- Package uart_pkg holds:
  - typedef enum parity_e {PARITY_NONE, PARITY_ODD, PARITY_EVEN};
  - typedef enum tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - function clk_per_bit(clk_hz, baud).
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, wdata, rdata, count) is instantiated once. The serializer FSM lives in uart_tx_fifo.

## Test plan
The bench uses CLK_HZ=1000, BAUD=100 (CLK_PER_BIT=10) unless stated.
- 8N1, push 0x4D once → tx falls 2 cycles after acceptance. Bits read at mid-bit are 0,1,0,1,1,0,0,1,0 then 1. Frame is 100 cycles; busy then drops.
- 7E2 (DATA_BITS=7, EVEN, STOP_BITS=2), push 0x41 → data bits 1,0,0,0,0,0,1, parity 0, two stop bits. Frame is 110 cycles.
- DATA_BITS=8, ODD, push 0x00 → parity bit 1. Push 0x01 → parity bit 0.
- FIFO_DEPTH=4, hold in_valid with 0x30..0x37 → first word popped, next 4 queued, in_ready low. Eight frames emitted contiguously (no gap at stop→start) in order 0x30..0x37; fifo_count never exceeds 4.
- Queue 3 words, assert flush mid-frame of the first with a simultaneous push of 0x55 → first frame completes, then 0x55 is transmitted and nothing else.
- Assert reset during DATA of a frame → tx=1 and fifo_count=0 on the next edge; a subsequent push of 0x4D transmits correctly.
